// File: rtl/ahb_slave_if_if.sv
// Bus bundle between the AHB master side and the AHB front end of the AHB-to-APB bridge.
// Names are from the front end's point of view: i_* flow into it, o_* flow out of it.
interface ahb_slave_if_if;
  logic        i_hsel;
  logic [1:0]  i_htrans;
  logic        i_hwrite;
  logic [2:0]  i_hsize;
  logic [31:0] i_haddr;
  logic [31:0] i_hwdata;
  logic        i_hready_in;
  logic        o_hready_out;
  logic [1:0]  o_hresp;
  logic        o_valid;
  logic [31:0] o_haddr1;
  logic [31:0] o_haddr2;
  logic [31:0] o_hwdata1;
  logic [31:0] o_hwdata2;
  logic        o_hwrite_reg;
  logic        o_hwrite_reg1;
  logic [2:0]  o_tempselx;

  modport master (
    output i_hsel, i_htrans, i_hwrite, i_hsize, i_haddr, i_hwdata, i_hready_in,
    input  o_hready_out, o_hresp, o_valid, o_haddr1, o_haddr2, o_hwdata1, o_hwdata2,
           o_hwrite_reg, o_hwrite_reg1, o_tempselx
  );

  modport slave (
    input  i_hsel, i_htrans, i_hwrite, i_hsize, i_haddr, i_hwdata, i_hready_in,
    output o_hready_out, o_hresp, o_valid, o_haddr1, o_haddr2, o_hwdata1, o_hwdata2,
           o_hwrite_reg, o_hwrite_reg1, o_tempselx
  );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: two-deep address-phase pipeline, APB slave
// decode, Valid qualifier for the bridge FSM and a two-cycle ERROR response.
module ahb_slave_if #(
  parameter logic [31:0] APB_BASE = 32'h8000_0000,
  parameter int unsigned WIN_BITS = 26,
  parameter int unsigned SEL_LSB  = 24
) (
  input  logic          i_hclk,
  input  logic          i_hrst,
  ahb_slave_if_if.slave bus
);

  localparam logic [1:0] ST_OKAY    = 2'b00;
  localparam logic [1:0] ST_ERR1    = 2'b01;
  localparam logic [1:0] ST_ERR2    = 2'b10;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  function automatic logic [2:0] seg_onehot(input logic [1:0] seg);
    case (seg)
      2'b00:   seg_onehot = 3'b001;
      2'b01:   seg_onehot = 3'b010;
      2'b10:   seg_onehot = 3'b100;
      default: seg_onehot = 3'b000;
    endcase
  endfunction

  // Byte always fits; half needs bit 0 clear, word needs bits 1:0 clear; wider sizes are illegal.
  function automatic logic size_bad(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      3'b000:  size_bad = 1'b0;
      3'b001:  size_bad = lsb[0];
      3'b010:  size_bad = |lsb;
      default: size_bad = 1'b1;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [1:0]  r_hresp;
  logic        w_hready_out;
  logic        w_active;
  logic        w_in_win;
  logic [1:0]  w_seg;
  logic        w_illegal;
  logic        w_adv;
  logic        w_valid;
  logic [31:0] r_haddr1;
  logic [31:0] r_haddr2;
  logic [31:0] r_hwdata1;
  logic [31:0] r_hwdata2;
  logic        r_hwrite_reg;
  logic        r_hwrite_reg1;
  logic [2:0]  r_tempselx;

  assign w_active  = bus.i_hsel & bus.i_htrans[1];
  assign w_in_win  = (bus.i_haddr[31:WIN_BITS] == APB_BASE[31:WIN_BITS]);
  assign w_seg     = bus.i_haddr[SEL_LSB+1:SEL_LSB];
  assign w_illegal = w_active & (~w_in_win | (w_seg == 2'b11) |
                                 size_bad(bus.i_hsize, bus.i_haddr[1:0]));
  assign w_adv     = bus.i_hready_in & (r_state == ST_OKAY);
  assign w_valid   = w_active & ~w_illegal & w_adv;

  // Error FSM next state and the HREADY returned to the master.
  always_comb begin
    w_state_nxt  = ST_OKAY;
    w_hready_out = bus.i_hready_in;
    case (r_state)
      ST_OKAY: begin
        w_hready_out = bus.i_hready_in;
        if (w_illegal && bus.i_hready_in) begin
          w_state_nxt = ST_ERR1;
        end else begin
          w_state_nxt = ST_OKAY;
        end
      end
      ST_ERR1: begin
        w_hready_out = 1'b0;
        w_state_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        w_hready_out = 1'b1;
        w_state_nxt  = ST_OKAY;
      end
      default: begin
        w_hready_out = 1'b0;
        w_state_nxt  = ST_OKAY;
      end
    endcase
  end

  // Error state and registered response; ERROR is shown for both ERR1 and ERR2.
  always_ff @(posedge i_hclk or posedge i_hrst) begin
    if (i_hrst) begin
      r_state <= ST_OKAY;
      r_hresp <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      r_hresp <= (w_state_nxt == ST_OKAY) ? RESP_OKAY : RESP_ERROR;
    end
  end

  // Address-phase pipeline; the whole pipeline stalls on wait states and during ERROR.
  always_ff @(posedge i_hclk or posedge i_hrst) begin
    if (i_hrst) begin
      r_haddr1      <= 32'h0000_0000;
      r_haddr2      <= 32'h0000_0000;
      r_hwdata1     <= 32'h0000_0000;
      r_hwdata2     <= 32'h0000_0000;
      r_hwrite_reg  <= 1'b0;
      r_hwrite_reg1 <= 1'b0;
      r_tempselx    <= 3'b000;
    end else if (w_adv) begin
      r_haddr1      <= bus.i_haddr;
      r_haddr2      <= r_haddr1;
      r_hwdata1     <= bus.i_hwdata;
      r_hwdata2     <= r_hwdata1;
      r_hwrite_reg  <= bus.i_hwrite;
      r_hwrite_reg1 <= r_hwrite_reg;
      r_tempselx    <= w_valid ? seg_onehot(w_seg) : 3'b000;
    end
  end

  assign bus.o_hready_out  = w_hready_out;
  assign bus.o_hresp       = r_hresp;
  assign bus.o_valid       = w_valid;
  assign bus.o_haddr1      = r_haddr1;
  assign bus.o_haddr2      = r_haddr2;
  assign bus.o_hwdata1     = r_hwdata1;
  assign bus.o_hwdata2     = r_hwdata2;
  assign bus.o_hwrite_reg  = r_hwrite_reg;
  assign bus.o_hwrite_reg1 = r_hwrite_reg1;
  assign bus.o_tempselx    = r_tempselx;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: a vector table for single-cycle behaviour plus
// hand-written sequences for the ERROR response, wait states and reset mid-error.
module tb_ahb_slave_if;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ahb_slave_if_if bus ();

  ahb_slave_if dut (
    .i_hclk (clk),
    .i_hrst (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        valid;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata1;
    logic [2:0]  sel;
    logic        wr;
    logic        wr1;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bus.i_hsel      = sel;
    bus.i_htrans    = tr;
    bus.i_hwrite    = wr;
    bus.i_hsize     = sz;
    bus.i_haddr     = a;
    bus.i_hwdata    = d;
    bus.i_hready_in = rdy;
  endtask

  // Illegal NONSEQ, then a legal phase presented through ERR1/ERR2 that is only taken after ERR2.
  task automatic err_seq(input string tag, input logic [31:0] a, input logic [2:0] sz);
    drive(1'b1, 2'b10, 1'b1, sz, a, 32'h0000_0000, 1'b1);
    #1;
    chk({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd0);
    chk({tag, "_rdy_okay"}, {31'd0, bus.o_hready_out}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_err1_resp"}, {30'd0, bus.o_hresp}, 32'd1);
    chk({tag, "_err1_rdy"}, {31'd0, bus.o_hready_out}, 32'd0);
    chk({tag, "_err1_haddr1"}, bus.o_haddr1, a);
    chk({tag, "_err1_sel"}, {29'd0, bus.o_tempselx}, 32'd0);
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h8000_0020, 32'h0000_00C0, 1'b1);
    #1;
    chk({tag, "_err1_valid"}, {31'd0, bus.o_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_err2_resp"}, {30'd0, bus.o_hresp}, 32'd1);
    chk({tag, "_err2_rdy"}, {31'd0, bus.o_hready_out}, 32'd1);
    chk({tag, "_err2_hold"}, bus.o_haddr1, a);
    chk({tag, "_err2_valid"}, {31'd0, bus.o_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_ok_resp"}, {30'd0, bus.o_hresp}, 32'd0);
    chk({tag, "_ok_rdy"}, {31'd0, bus.o_hready_out}, 32'd1);
    chk({tag, "_ok_valid"}, {31'd0, bus.o_valid}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_next_haddr1"}, bus.o_haddr1, 32'h8000_0020);
    chk({tag, "_next_haddr2"}, bus.o_haddr2, a);
    chk({tag, "_next_sel"}, {29'd0, bus.o_tempselx}, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //              sel   trans  wr    size    haddr          hwdata         rdy  | valid haddr1         haddr2         hwdata1        sel     wr    wr1
    vecs[0] = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h8100_0004, 32'hAAAA_0001, 1'b1, 1'b1, 32'h8100_0004, 32'h0000_0000, 32'hAAAA_0001, 3'b010, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 2'b11, 1'b0, 3'b001, 32'h8000_0002, 32'h1111_2222, 1'b1, 1'b1, 32'h8000_0002, 32'h8100_0004, 32'h1111_2222, 3'b001, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 2'b10, 1'b1, 3'b000, 32'h8200_0003, 32'h0000_0003, 1'b1, 1'b1, 32'h8200_0003, 32'h8000_0002, 32'h0000_0003, 3'b100, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'b01, 1'b0, 3'b010, 32'h8000_0000, 32'h0000_0004, 1'b1, 1'b0, 32'h8000_0000, 32'h8200_0003, 32'h0000_0004, 3'b000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 2'b10, 1'b1, 3'b010, 32'h8100_0000, 32'h0000_0005, 1'b1, 1'b0, 32'h8100_0000, 32'h8000_0000, 32'h0000_0005, 3'b000, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 2'b00, 1'b0, 3'b011, 32'h1234_5678, 32'h0000_0006, 1'b1, 1'b0, 32'h1234_5678, 32'h8100_0000, 32'h0000_0006, 3'b000, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h8200_0008, 32'h0000_0077, 1'b0, 1'b0, 32'h1234_5678, 32'h8100_0000, 32'h0000_0006, 3'b000, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h8000_0010, 32'h0000_0088, 1'b0, 1'b0, 32'h1234_5678, 32'h8100_0000, 32'h0000_0006, 3'b000, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h8000_0010, 32'h0000_0007, 1'b1, 1'b1, 32'h8000_0010, 32'h1234_5678, 32'h0000_0007, 3'b001, 1'b1, 1'b0};

    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    #12;
    chk("rst_resp", {30'd0, bus.o_hresp}, 32'd0);
    chk("rst_rdy", {31'd0, bus.o_hready_out}, 32'd1);
    chk("rst_haddr1", bus.o_haddr1, 32'd0);
    chk("rst_sel", {29'd0, bus.o_tempselx}, 32'd0);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].hsel, vecs[i].htrans, vecs[i].hwrite, vecs[i].hsize,
            vecs[i].haddr, vecs[i].hwdata, vecs[i].hready_in);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, bus.o_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d_rdy", i), {31'd0, bus.o_hready_out}, {31'd0, vecs[i].hready_in});
      @(posedge clk); #1;
      chk($sformatf("v%0d_haddr1", i), bus.o_haddr1, vecs[i].haddr1);
      chk($sformatf("v%0d_haddr2", i), bus.o_haddr2, vecs[i].haddr2);
      chk($sformatf("v%0d_hwdata1", i), bus.o_hwdata1, vecs[i].hwdata1);
      chk($sformatf("v%0d_sel", i), {29'd0, bus.o_tempselx}, {29'd0, vecs[i].sel});
      chk($sformatf("v%0d_wr", i), {31'd0, bus.o_hwrite_reg}, {31'd0, vecs[i].wr});
      chk($sformatf("v%0d_wr1", i), {31'd0, bus.o_hwrite_reg1}, {31'd0, vecs[i].wr1});
      chk($sformatf("v%0d_resp", i), {30'd0, bus.o_hresp}, 32'd0);
    end
    chk("hwdata2_after_table", bus.o_hwdata2, 32'h0000_0006);

    // Illegal transfer during a wait state is not taken until Hready_in rises.
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h4000_0000, 32'h0000_0000, 1'b0);
    #1;
    chk("wait_ill_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("wait_ill_rdy", {31'd0, bus.o_hready_out}, 32'd0);
    @(posedge clk); #1;
    chk("wait_ill_resp", {30'd0, bus.o_hresp}, 32'd0);
    chk("wait_ill_hold", bus.o_haddr1, 32'h8000_0010);
    err_seq("win", 32'h4000_0000, 3'b010);

    err_seq("seg11", 32'h8300_0000, 3'b010);
    err_seq("word_mis", 32'h8000_0002, 3'b010);
    err_seq("size3", 32'h8000_0000, 3'b011);
    err_seq("half_mis", 32'h8000_0001, 3'b001);

    // Asynchronous reset while in ERR1.
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h8300_0000, 32'h0000_0000, 1'b1);
    @(posedge clk); #1;
    chk("rerr_err1_resp", {30'd0, bus.o_hresp}, 32'd1);
    chk("rerr_err1_rdy", {31'd0, bus.o_hready_out}, 32'd0);
    drive(1'b0, 2'b00, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rerr_resp", {30'd0, bus.o_hresp}, 32'd0);
    chk("rerr_rdy", {31'd0, bus.o_hready_out}, 32'd1);
    chk("rerr_haddr1", bus.o_haddr1, 32'd0);
    chk("rerr_sel", {29'd0, bus.o_tempselx}, 32'd0);
    bus.i_hready_in = 1'b0;
    #1;
    chk("rerr_rdy_follow", {31'd0, bus.o_hready_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_hready_in = 1'b1;
    @(posedge clk); #1;
    chk("rerr_post_resp", {30'd0, bus.o_hresp}, 32'd0);
    chk("rerr_post_rdy", {31'd0, bus.o_hready_out}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
